// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer.
package alu_issue_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;
   localparam int IMM_W  = 6;

   // ALU function codes; the sequencer forwards them without interpreting them
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SHL = 3'b100;
   localparam logic [2:0] ALU_SHR = 3'b101;
   localparam logic [2:0] ALU_MRG = 3'b110;

   // Instruction field bit positions
   localparam int F_HI    = 15;
   localparam int F_LO    = 13;
   localparam int RD_HI   = 12;
   localparam int RD_LO   = 10;
   localparam int RS_HI   = 9;
   localparam int RS_LO   = 7;
   localparam int IMM_SEL = 6;
   localparam int IMM_HI  = 5;
   localparam int IMM_LO  = 0;
   localparam int RT_HI   = 5;
   localparam int RT_LO   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WB    = 2'd2
   } state_t;

   // Immediates are always zero-extended to the datapath width
   function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){1'b0}}, imm};
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8-entry register file: R0 reads as zero, two operand read ports plus a debug port.
module alu_issue_regfile
   import alu_issue_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs_addr,
   output logic [DATA_W-1:0] rs_data,
   input  logic [REG_AW-1:0] rt_addr,
   output logic [DATA_W-1:0] rt_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [0:(1<<REG_AW)-1];

   // Storage: cleared on reset, written on enable except for the hardwired R0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < (1<<REG_AW); i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Combinational reads, with address 0 forced to zero
   always_comb begin
      rs_data  = (rs_addr  == '0) ? '0 : regs[rs_addr];
      rt_data  = (rt_addr  == '0) ? '0 : regs[rt_addr];
      dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
   end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback sequencer driving an external combinational ALU.
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [DATA_W-1:0] alu_x,
   output logic [DATA_W-1:0] alu_y,
   output logic [2:0]        alu_f,
   input  logic [DATA_W-1:0] alu_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [REG_AW-1:0] res_rd,
   output logic              busy,
   input  logic [REG_AW-1:0] dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   state_t            state;
   state_t            next_state;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic              accept;
   logic              wb_en;

   alu_issue_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs_addr  (instr[RS_HI:RS_LO]),
      .rs_data  (rs_data),
      .rt_addr  (instr[RT_HI:RT_LO]),
      .rt_data  (rt_data),
      .dbg_addr (dbg_raddr),
      .dbg_data (dbg_rdata),
      .we       (wb_en),
      .waddr    (res_rd),
      .wdata    (alu_out)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake outputs; ISSUE always lasts exactly one cycle
   always_comb begin
      next_state  = state;
      instr_ready = 1'b0;
      busy        = 1'b1;
      accept      = 1'b0;
      wb_en       = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
            accept      = instr_valid;
            if (instr_valid) begin
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            wb_en      = 1'b1;
            next_state = WB;
         end
         WB: begin
            if (res_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath: latch operands on accept, capture the ALU result at the end of ISSUE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_x     <= '0;
         alu_y     <= '0;
         alu_f     <= 3'b000;
         res_rd    <= '0;
         res_data  <= '0;
         res_valid <= 1'b0;
      end else begin
         if (accept) begin
            alu_x  <= rs_data;
            alu_y  <= instr[IMM_SEL] ? zext_imm(instr[IMM_HI:IMM_LO]) : rt_data;
            alu_f  <= instr[F_HI:F_LO];
            res_rd <= instr[RD_HI:RD_LO];
         end
         if (state == ISSUE) begin
            res_data  <= alu_out;
            res_valid <= 1'b1;
         end else if ((state == WB) && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for the ALU issue sequencer, with a behavioural ALU.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic [2:0]  alu_f;
   logic [15:0] alu_out;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic [2:0]  res_rd;
   logic        busy;
   logic [2:0]  dbg_raddr;
   logic [15:0] dbg_rdata;

   int total = 0;
   int bad   = 0;

   alu_issue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_x       (alu_x),
      .alu_y       (alu_y),
      .alu_f       (alu_f),
      .alu_out     (alu_out),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_rd      (res_rd),
      .busy        (busy),
      .dbg_raddr   (dbg_raddr),
      .dbg_rdata   (dbg_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: shifts move by y+1, merge takes high byte of x and low byte of y
   always_comb begin
      alu_out = 16'h0000;
      case (alu_f)
         3'b000: alu_out = alu_x + alu_y;
         3'b001: alu_out = alu_x - alu_y;
         3'b010: alu_out = alu_x & alu_y;
         3'b011: alu_out = alu_x | alu_y;
         3'b100: alu_out = alu_x << (alu_y + 16'd1);
         3'b101: alu_out = alu_x >> (alu_y + 16'd1);
         3'b110: alu_out = {alu_x[15:8], alu_y[7:0]};
         default: alu_out = alu_x ^ alu_y;
      endcase
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one instruction for one accept edge; returns at the negedge inside ISSUE
   task automatic send(input logic [15:0] w);
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = w;
      step();
      instr_valid = 1'b0;
   endtask

   // From ISSUE: advance into WB, then release the result
   task automatic drain();
      step();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   task automatic check_reg(input logic [2:0] a, input logic [15:0] exp, input string name);
      dbg_raddr = a;
      #1;
      total++;
      if (dbg_rdata !== exp) begin
         bad++;
         $display("[TB] FAIL %s R%0d: got %h want %h", name, a, dbg_rdata, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      #1;
      total++;
      if ({instr_ready, res_valid, busy} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL reset_ctrl: got rdy/val/busy=%b want 100", {instr_ready, res_valid, busy});
      end
      total++;
      if ({alu_x, alu_y, alu_f, res_data, res_rd} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_data: got x=%h y=%h f=%b d=%h rd=%0d want zeros", alu_x, alu_y, alu_f, res_data, res_rd);
      end
      for (int i = 0; i < 8; i++) begin
         check_reg(i[2:0], 16'h0000, "reset_reg");
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (instr_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_ready: got %b want 1", instr_ready);
      end
   endtask

   task automatic test_imm_add();
      send(16'h0445);
      total++;
      if ({alu_x, alu_y, alu_f, busy, instr_ready} !== {16'd0, 16'd5, 3'b000, 1'b1, 1'b0}) begin
         bad++;
         $display("[TB] FAIL imm_issue: got x=%h y=%h f=%b busy=%b rdy=%b want 0 5 000 1 0", alu_x, alu_y, alu_f, busy, instr_ready);
      end
      step();
      total++;
      if ({res_valid, res_data, res_rd} !== {1'b1, 16'd5, 3'd1}) begin
         bad++;
         $display("[TB] FAIL imm_result: got v=%b d=%h rd=%0d want 1 0005 1", res_valid, res_data, res_rd);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      total++;
      if ({res_valid, busy, instr_ready} !== 3'b001) begin
         bad++;
         $display("[TB] FAIL imm_return: got v/busy/rdy=%b want 001", {res_valid, busy, instr_ready});
      end
      check_reg(3'd1, 16'd5, "imm_r1");
   endtask

   task automatic test_reg_sub();
      send(16'h0843);
      drain();
      check_reg(3'd2, 16'd3, "load_r2");
      send(16'h2C90);
      total++;
      if ({alu_x, alu_y, alu_f} !== {16'd5, 16'd3, 3'b001}) begin
         bad++;
         $display("[TB] FAIL sub_issue: got x=%h y=%h f=%b want 5 3 001", alu_x, alu_y, alu_f);
      end
      step();
      total++;
      if ({res_valid, res_data, res_rd} !== {1'b1, 16'd2, 3'd3}) begin
         bad++;
         $display("[TB] FAIL sub_result: got v=%b d=%h rd=%0d want 1 0002 3", res_valid, res_data, res_rd);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check_reg(3'd3, 16'd2, "sub_r3");
   endtask

   task automatic test_r0_shift();
      send(16'h80C1);
      total++;
      if ({alu_x, alu_y, alu_f} !== {16'd5, 16'd1, 3'b100}) begin
         bad++;
         $display("[TB] FAIL shl_issue: got x=%h y=%h f=%b want 5 1 100", alu_x, alu_y, alu_f);
      end
      step();
      total++;
      if ({res_valid, res_data, res_rd} !== {1'b1, 16'd20, 3'd0}) begin
         bad++;
         $display("[TB] FAIL shl_result: got v=%b d=%h rd=%0d want 1 0014 0", res_valid, res_data, res_rd);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check_reg(3'd0, 16'd0, "r0_zero");
   endtask

   task automatic test_backpressure();
      send(16'h7490);
      step();
      instr_valid = 1'b1;
      instr       = 16'h11C7;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if ({res_valid, res_data, res_rd, instr_ready, busy} !== {1'b1, 16'd7, 3'd5, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL bp_hold%0d: got v=%b d=%h rd=%0d rdy=%b busy=%b want 1 0007 5 0 1", i, res_valid, res_data, res_rd, instr_ready, busy);
         end
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      total++;
      if ({res_valid, busy, instr_ready} !== 3'b001) begin
         bad++;
         $display("[TB] FAIL bp_release: got v/busy/rdy=%b want 001", {res_valid, busy, instr_ready});
      end
      step();
      instr_valid = 1'b0;
      total++;
      if ({busy, alu_x, alu_y, alu_f} !== {1'b1, 16'd2, 16'd7, 3'b000}) begin
         bad++;
         $display("[TB] FAIL bp_accept: got busy=%b x=%h y=%h f=%b want 1 2 7 000", busy, alu_x, alu_y, alu_f);
      end
      step();
      total++;
      if ({res_valid, res_data, res_rd} !== {1'b1, 16'd9, 3'd4}) begin
         bad++;
         $display("[TB] FAIL bp_pending: got v=%b d=%h rd=%0d want 1 0009 4", res_valid, res_data, res_rd);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check_reg(3'd5, 16'd7, "bp_r5");
      check_reg(3'd4, 16'd9, "bp_r4");
   endtask

   task automatic test_func_passthru();
      send(16'hFAFF);
      total++;
      if ({alu_x, alu_y, alu_f} !== {16'd7, 16'd63, 3'b111}) begin
         bad++;
         $display("[TB] FAIL f111_issue: got x=%h y=%h f=%b want 7 3f 111", alu_x, alu_y, alu_f);
      end
      drain();
      check_reg(3'd6, 16'd56, "f111_r6");
   endtask

   task automatic test_reset_mid();
      send(16'h0445);
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, res_valid, instr_ready} !== 3'b001) begin
         bad++;
         $display("[TB] FAIL midrst_state: got busy/v/rdy=%b want 001", {busy, res_valid, instr_ready});
      end
      for (int i = 0; i < 8; i++) begin
         check_reg(i[2:0], 16'h0000, "midrst_reg");
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({res_valid, busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL midrst_quiet%0d: got v/busy=%b want 00", i, {res_valid, busy});
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      res_ready   = 1'b0;
      dbg_raddr   = 3'd0;
      test_reset();
      test_imm_add();
      test_reg_sub();
      test_r0_shift();
      test_backpressure();
      test_func_passthru();
      test_reset();
      test_imm_add();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
